mem_request_controller: RTL and testbench

//  Request-side front end for the 16-bit synchronous memory block (1-cycle registered read).

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_byte_merge.sv | 19 +
 rtl/mem_request_controller.sv | 137 +++++++++++++
 tb/tb_mem_request_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory request controller.
// The RMW_MERGE state and lane helper only matter when MEM_BYTE_WRITE_EN is defined.
package mem_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_MERGE = 1'b1
    } ctrl_state_e;

    localparam int          LANE_HI      = 1;
    localparam int          LANE_LO      = 0;
    localparam logic [1:0]  BYTE_EN_FULL = 2'b11;

    // Expands a 2-bit lane enable into a 16-bit bit mask.
    function automatic logic [15:0] lane_mask(input logic [1:0] byte_en);
        return {{8{byte_en[LANE_HI]}}, {8{byte_en[LANE_LO]}}};
    endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational byte-lane merge used by the read-modify-write path.
// Only built when MEM_BYTE_WRITE_EN is defined.
`ifdef MEM_BYTE_WRITE_EN
module mem_byte_merge
    import mem_ctrl_pkg::*;
(
    input  logic [15:0] old_data,
    input  logic [15:0] new_data,
    input  logic [1:0]  byte_en,
    output logic [15:0] merged_data
);

    logic [15:0] mask;

    assign mask        = lane_mask(byte_en);
    assign merged_data = (new_data & mask) | (old_data & ~mask);

endmodule
`endif

// File: rtl/mem_request_controller.sv
// Valid/ready request front end for a 16-bit memory with a 1-cycle registered read.
// Define MEM_BYTE_WRITE_EN to enable byte-lane writes via a read-modify-write cycle.
module mem_request_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [15:0]           req_data,
    input  logic [1:0]            req_byte_en,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_data,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  req_fire, rd_fire, wr_fire, resp_fire;

    assign req_fire   = req_valid && req_ready;
    assign rd_fire    = req_fire && !req_write;
    assign wr_fire    = req_fire && req_write;
    assign resp_fire  = resp_valid_q && resp_ready;
    assign resp_valid = resp_valid_q;
    assign resp_data  = mem_data_out;

    // A new read takes priority over clearing: it reuses the slot freed by this cycle's handshake.
    always_comb begin
        rd_addr_d    = rd_addr_q;
        resp_valid_d = resp_valid_q;
        if (rd_fire) begin
            rd_addr_d    = req_address;
            resp_valid_d = 1'b1;
        end else if (resp_fire) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef MEM_BYTE_WRITE_EN
    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [1:0]            wr_be_q, wr_be_d;
    logic [15:0]           merged_data;
    logic                  partial_write;

    assign partial_write = req_write && (req_byte_en != BYTE_EN_FULL) && (req_byte_en != 2'b00);

    // A partial write borrows the read port, so it must wait until no read data is being held.
    assign req_ready = (state_q == IDLE) && (!resp_valid_q || resp_ready)
                       && !(partial_write && resp_valid_q) && !reset;

    mem_byte_merge u_merge (
        .old_data    (mem_data_out),
        .new_data    (wr_data_q),
        .byte_en     (wr_be_q),
        .merged_data (merged_data)
    );

    always_comb begin
        state_d           = state_q;
        wr_addr_d         = wr_addr_q;
        wr_data_d         = wr_data_q;
        wr_be_d           = wr_be_q;
        mem_write_enable  = 1'b0;
        mem_write_address = req_address;
        mem_data_in       = req_data;
        mem_read_address  = rd_fire ? req_address : rd_addr_q;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    if (req_byte_en == BYTE_EN_FULL) begin
                        mem_write_enable = 1'b1;
                    end else if (partial_write) begin
                        mem_read_address = req_address;
                        wr_addr_d        = req_address;
                        wr_data_d        = req_data;
                        wr_be_d          = req_byte_en;
                        state_d          = RMW_MERGE;
                    end
                end
            end
            RMW_MERGE: begin
                mem_write_enable  = !reset;
                mem_write_address = wr_addr_q;
                mem_data_in       = merged_data;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_be_q   <= wr_be_d;
        end
    end
`else
    logic unused_byte_en;

    assign unused_byte_en    = ^req_byte_en;
    assign req_ready         = (!resp_valid_q || resp_ready) && !reset;
    assign mem_write_enable  = wr_fire;
    assign mem_write_address = req_address;
    assign mem_data_in       = req_data;
    assign mem_read_address  = rd_fire ? req_address : rd_addr_q;
`endif

endmodule

// File: tb/tb_mem_request_controller.sv
// Randomized scoreboard bench for mem_request_controller with a behavioural memory model.
// Byte-lane tests run only when MEM_BYTE_WRITE_EN is defined.
module tb_mem_request_controller;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [15:0]   req_data = '0;
    logic [1:0]    req_byte_en = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [15:0]   resp_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_read_address;
    logic [AW-1:0] mem_write_address;
    logic [15:0]   mem_data_in;
    logic [15:0]   mem_data_out = '0;

    logic [15:0]   mem_array [0:255];
    logic [15:0]   ref_mem   [0:255];
    logic [15:0]   exp_q [$];

    int            checks = 0;
    int            errors = 0;

    bit            model_pending = 0;
    bit            model_rmw = 0;
    logic [AW-1:0] model_rmw_addr = '0;
    logic [15:0]   model_rmw_data = '0;
    logic [1:0]    model_rmw_be = '0;

    always #5 clock = ~clock;

    mem_request_controller #(.ADDR_WIDTH(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_data          (req_data),
        .req_byte_en       (req_byte_en),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .mem_write_enable  (mem_write_enable),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out)
    );

    // Memory block: write and registered read on the same edge, read returns pre-write contents.
    always @(posedge clock) begin
        if (mem_write_enable) mem_array[mem_write_address] <= mem_data_in;
        mem_data_out <= mem_array[mem_read_address];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic bit is_partial(input bit w, input logic [1:0] be);
`ifdef MEM_BYTE_WRITE_EN
        return w && (be == 2'b01 || be == 2'b10);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_full(input bit w, input logic [1:0] be);
`ifdef MEM_BYTE_WRITE_EN
        return w && (be == 2'b11);
`else
        return w;
`endif
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // One bus cycle: drive inputs after the edge, check rules against the model, advance the model.
    task automatic applyStimulus(input bit rst, input bit v, input bit w, input logic [AW-1:0] a,
                                 input logic [15:0] d, input logic [1:0] be, input bit rr,
                                 output bit acc);
        bit exp_ready, exp_we;
        @(posedge clock);
        #1;
        reset = rst; req_valid = v; req_write = w; req_address = a;
        req_data = d; req_byte_en = be; resp_ready = rr;
        #1;
        exp_ready = !rst && !model_rmw && (!model_pending || rr) && !(model_pending && is_partial(w, be));
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, model_pending);
        acc = v && req_ready;
        exp_we = 0;
        if (model_rmw && !rst) begin
            exp_we = 1;
            check("rmw_wr_addr", mem_write_address, model_rmw_addr);
            check("rmw_wr_data", mem_data_in, merge(ref_mem[model_rmw_addr], model_rmw_data, model_rmw_be));
            ref_mem[model_rmw_addr] = merge(ref_mem[model_rmw_addr], model_rmw_data, model_rmw_be);
        end else if (acc && is_full(w, be)) begin
            exp_we = 1;
            check("wr_addr", mem_write_address, a);
            check("wr_data", mem_data_in, d);
        end
        check("mem_write_enable", mem_write_enable, exp_we);
        if (acc && (!w || is_partial(w, be))) check("rd_addr", mem_read_address, a);

        if (acc && is_full(w, be)) ref_mem[a] = d;
        if (acc && !w) exp_q.push_back(ref_mem[a]);
        model_rmw = !rst && acc && is_partial(w, be);
        if (model_rmw) begin
            model_rmw_addr = a; model_rmw_data = d; model_rmw_be = be;
        end
        if (rst) begin
            model_pending = 0;
            exp_q.delete();
        end else if (acc && !w) begin
            model_pending = 1;
        end else if (model_pending && rr) begin
            model_pending = 0;
        end
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                         input logic [1:0] be, output int waits);
        bit acc;
        waits = 0;
        applyStimulus(0, 1, w, a, d, be, 1, acc);
        while (!acc && waits < 50) begin
            waits++;
            applyStimulus(0, 1, w, a, d, be, 1, acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout actual=not_accepted required=accepted addr=%0h", a);
        end
    endtask

    task automatic idle(output bit acc);
        applyStimulus(0, 0, 0, '0, '0, 2'b00, 1, acc);
    endtask

    // Monitor: pops the scoreboard on every response handshake and watches hold stability.
    logic [15:0] held_data = '0;
    bit          stalled = 0;
    always @(negedge clock) begin
        if (reset) begin
            stalled = 0;
        end else if (resp_valid) begin
            if (stalled) checkOutput("resp_stable", resp_data, held_data);
            if (resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL resp_unexpected actual=%0h required=no_response", resp_data);
                end else begin
                    checkOutput("resp_data", resp_data, exp_q.pop_front());
                end
                stalled = 0;
            end else begin
                stalled   = 1;
                held_data = resp_data;
            end
        end else begin
            stalled = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        check(name, {16'h0, actual}, {16'h0, required});
    endtask

    initial begin
        bit acc;
        int waits;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = 16'(i * 37) ^ 16'hC3A5;
            ref_mem[i]   = 16'(i * 37) ^ 16'hC3A5;
        end

        // Reset with a request waiting: must not be accepted, nothing written.
        applyStimulus(1, 1, 1, 8'h55, 16'hDEAD, 2'b11, 1, acc);
        applyStimulus(1, 1, 0, 8'h55, 16'h0000, 2'b11, 1, acc);
        check("reset_no_accept", acc, 0);

        // Write then read the same address on the next cycle.
        issue(1, 8'h10, 16'h1234, 2'b11, waits);
        issue(0, 8'h10, 16'h0000, 2'b00, waits);
        idle(acc);
        check("t1_resp_valid", resp_valid, 1);
        checkOutput("t1_resp_data", resp_data, 16'h1234);

        // Back-to-back reads sustain one per cycle.
        for (int i = 1; i <= 4; i++) begin
            issue(0, AW'(i), 16'h0, 2'b00, waits);
            check("t2_waits", waits, 0);
        end
        idle(acc);

        // Held response blocks new requests and keeps data stable.
        issue(0, 8'h05, 16'h0, 2'b00, waits);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 8'h06, 16'h0, 2'b00, 0, acc);
            check("t3_blocked", acc, 0);
            checkOutput("t3_hold_data", resp_data, ref_mem[5]);
        end
        applyStimulus(0, 1, 0, 8'h06, 16'h0, 2'b00, 1, acc);
        check("t3_accept", acc, 1);
        idle(acc);

`ifdef MEM_BYTE_WRITE_EN
        // Low-lane write merges into existing data and stalls requests for one cycle.
        issue(1, 8'h20, 16'hAABB, 2'b11, waits);
        issue(1, 8'h20, 16'h1122, 2'b01, waits);
        applyStimulus(0, 1, 0, 8'h21, 16'h0, 2'b00, 1, acc);
        check("t4_stall", acc, 0);
        check("t4_merge_we", mem_write_enable, 1);
        issue(0, 8'h20, 16'h0, 2'b00, waits);
        idle(acc);
        checkOutput("t4_merged", resp_data, 16'hAA22);

        // Reset in the merge cycle drops the write.
        issue(1, 8'h40, 16'hBEEF, 2'b10, waits);
        applyStimulus(1, 0, 0, '0, '0, 2'b00, 1, acc);
        check("t5_no_we", mem_write_enable, 0);
        idle(acc);
        check("t5_ready", req_ready, 1);
        check("t5_resp_valid", resp_valid, 0);
        issue(0, 8'h40, 16'h0, 2'b00, waits);
        idle(acc);

        // Empty lane mask leaves memory untouched.
        issue(1, 8'h30, 16'h5555, 2'b11, waits);
        issue(1, 8'h30, 16'hFFFF, 2'b00, waits);
        issue(0, 8'h30, 16'h0, 2'b00, waits);
        idle(acc);
        checkOutput("t6_unchanged", resp_data, 16'h5555);
`endif

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) != 0,
                          1'($urandom),
                          AW'($urandom_range(0, 15)),
                          16'($urandom),
                          2'($urandom),
                          $urandom_range(0, 3) != 0,
                          acc);
        end

        for (int i = 0; i < 4; i++) idle(acc);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
